// File: rtl/result_buf_pkg.sv
// -----------------------------------------------------------------------------
// result_buf_pkg
//   Shared types for the NPU result buffer.
//   drain_state_e : states of the drain engine that streams stored entries out.
// -----------------------------------------------------------------------------
package result_buf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } drain_state_e;

endpackage

// File: rtl/result_ram_sp.sv
// -----------------------------------------------------------------------------
// result_ram_sp
//   DEPTH x DATA_W single-clock storage array with a byte-enable write port
//   and one synchronous read port. Reads are read-first: a read and a write of
//   the same address in one cycle returns the previous contents. The array
//   itself is never reset.
// Ports
//   clk_i    : clock, rising edge
//   we_i     : write strobe (address must already be range-checked)
//   waddr_i  : write address
//   wdata_i  : write data
//   wbe_i    : byte enables, bit i gates wdata_i[8i+7:8i]
//   re_i     : read strobe
//   raddr_i  : read address (must already be range-checked)
//   rdata_o  : registered read data, updated only on cycles after re_i
// -----------------------------------------------------------------------------
module result_ram_sp #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 64,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [BE_W-1:0]   wbe_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Both the write and the read sample mem_q through non-blocking
    // semantics, which gives read-first behaviour on an address collision.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wbe_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/result_buffer.sv
// -----------------------------------------------------------------------------
// result_buffer
//   NPU result store between accumulator writeback and the host readout path.
//   Byte-enable write port, 1-cycle synchronous host read port, and a drain
//   engine that streams entries 0..hi_water-1 over a valid/ready interface.
// Ports
//   clk, rst                  : clock (rising edge), async active-high reset
//   wr_en/wr_addr/wr_data/wr_be : write port; out-of-range writes are dropped
//   rd_en/rd_addr             : host read request, accepted only when idle
//   rd_data/rd_valid          : host read result, one cycle after acceptance
//   drain_start               : pulse, start streaming 0..hi_water-1
//   clear                     : pulse, hi_water := 0 and abort any drain
//   out_valid/out_ready/out_data/out_addr/out_last : drain stream
//   busy                      : drain engine not idle
//   drain_done                : 1-cycle pulse at the end of a drain
//   hi_water                  : highest written address + 1
//   err                       : 1-cycle pulse when a write or read is dropped
//   dbg_state                 : current drain engine state
//
// Drain stream handshake: a beat transfers on a rising edge where out_valid
// and out_ready are both 1. Once out_valid is raised, out_valid, out_data,
// out_addr and out_last hold steady until that transfer (or clear/rst).
// out_valid never depends combinationally on out_ready.
// -----------------------------------------------------------------------------
module result_buffer
    import result_buf_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 64,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              drain_start,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              drain_done,
    output logic [ADDR_W:0]   hi_water,
    output logic              err,
    output drain_state_e      dbg_state
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

    drain_state_e      state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   end_q, end_d;
    logic [ADDR_W:0]   hw_q, hw_d;
    logic [ADDR_W:0]   hw_base;
    logic [ADDR_W:0]   wr_top;
    logic              rd_valid_q;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rd_hold_q;
    logic [DATA_W-1:0] ram_rdata;
    logic              wr_ok, rd_ok;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_raddr;
    logic              is_last;

    // Range checks are done one bit wider so DEPTH values that are not a
    // power of two reject the unused top of the address space.
    assign wr_ok  = wr_en && ({1'b0, wr_addr} < DEPTH_L);
    assign rd_ok  = rd_en && (state_q == IDLE) && ({1'b0, rd_addr} < DEPTH_L);
    assign err_d  = (wr_en && !wr_ok) || (rd_en && !rd_ok);
    assign wr_top = {1'b0, wr_addr} + ONE_L;

    // Read-port mux: the drain engine owns the port outside IDLE, host reads
    // are only accepted in IDLE, so the two never collide.
    assign ram_re    = (state_q == FETCH) || rd_ok;
    assign ram_raddr = (state_q == FETCH) ? ptr_q : rd_addr;

    result_ram_sp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_ok),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .wbe_i   (wr_be),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign is_last = ({1'b0, ptr_q} == (end_q - ONE_L));

    // hi_water: clear zeroes the base first so a same-cycle write still lands.
    always_comb begin
        hw_base = clear ? '0 : hw_q;
        hw_d    = hw_base;
        if (wr_ok && (wr_top > hw_base)) begin
            hw_d = wr_top;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        end_d   = end_q;
        unique case (state_q)
            IDLE: begin
                if (drain_start) begin
                    if (hw_q != '0) begin
                        end_d   = hw_q;
                        ptr_d   = '0;
                        state_d = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FETCH: state_d = SEND;
            SEND: begin
                if (out_ready) begin
                    if (is_last) begin
                        state_d = DONE;
                    end else begin
                        ptr_d   = ptr_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            end_q      <= '0;
            hw_q       <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            rd_hold_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            end_q      <= end_d;
            hw_q       <= hw_d;
            rd_valid_q <= rd_ok;
            err_q      <= err_d;
            // The RAM output register is shared with the drain engine, so the
            // host result is copied aside to survive later drain reads.
            if (rd_valid_q) begin
                rd_hold_q <= ram_rdata;
            end
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_valid_q ? ram_rdata : rd_hold_q;
    assign out_valid  = (state_q == SEND);
    assign out_data   = out_valid ? ram_rdata : '0;
    assign out_addr   = out_valid ? ptr_q : '0;
    assign out_last   = out_valid && is_last;
    assign busy       = (state_q != IDLE);
    assign drain_done = (state_q == DONE);
    assign hi_water   = hw_q;
    assign err        = err_q;
    assign dbg_state  = state_q;

endmodule
